// File: rtl/prio_fun_arbiter_if.sv
// Request/grant bundle between the two profile requesters and the arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants and executor control.
interface prio_fun_arbiter_if #(
   parameter int FW = 3
);
   logic          req_a;
   logic [FW-1:0] fun_a;
   logic          req_b;
   logic [FW-1:0] fun_b;
   logic          prio;
   logic          ack_a;
   logic          ack_b;
   logic          run;
   logic [FW-1:0] fun_out;
   logic [1:0]    owner;
   logic          done;

   modport master (
      output req_a, fun_a, req_b, fun_b, prio,
      input  ack_a, ack_b, run, fun_out, owner, done
   );

   modport slave (
      input  req_a, fun_a, req_b, fun_b, prio,
      output ack_a, ack_b, run, fun_out, owner, done
   );
endinterface

// File: rtl/prio_fun_arbiter.sv
// Shares one functionality executor between profiles A and B; equal codes merge into one run.
// Define ARB_RR_EN to resolve different-code conflicts round-robin instead of by prio.
//
// state | meaning
// IDLE  | arbitrate on sampled requests; also the DONE cycle after a run
// RUN   | executor enabled, down-counter runs HOLD-1 .. 0
module prio_fun_arbiter #(
   parameter int FW   = 3,
   parameter int HOLD = 4
) (
   input logic               clk,
   input logic               rst_n,
   prio_fun_arbiter_if.slave bus
);
   localparam int CW = $clog2(HOLD + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic          ack_a_q, ack_a_d;
   logic          ack_b_q, ack_b_d;
   logic          done_q, done_d;
   logic [FW-1:0] fun_q, fun_d;
   logic [1:0]    owner_q, owner_d;

   logic conflict;
   logic win_a;
   logic grant_a;
   logic grant_b;

   assign conflict = bus.req_a && bus.req_b && (bus.fun_a != bus.fun_b);

`ifdef ARB_RR_EN
   // Remembers the winner of the last different-code conflict; the loser of it wins the next one.
   logic rr_seen_q;
   logic rr_win_a_q;

   assign win_a = rr_seen_q ? !rr_win_a_q : bus.prio;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_seen_q  <= 1'b0;
         rr_win_a_q <= 1'b0;
      end else if (state_q == IDLE && conflict) begin
         rr_seen_q  <= 1'b1;
         rr_win_a_q <= win_a;
      end
   end
`else
   assign win_a = bus.prio;
`endif

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (conflict) begin
         grant_a = win_a;
         grant_b = !win_a;
      end else begin
         grant_a = bus.req_a;
         grant_b = bus.req_b;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      fun_d   = fun_q;
      owner_d = owner_q;
      ack_a_d = 1'b0;
      ack_b_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            run_d   = 1'b0;
            fun_d   = '0;
            owner_d = 2'b00;
            if (grant_a || grant_b) begin
               state_d = RUN;
               cnt_d   = CW'(HOLD - 1);
               run_d   = 1'b1;
               ack_a_d = grant_a;
               ack_b_d = grant_b;
               fun_d   = grant_a ? bus.fun_a : bus.fun_b;
               owner_d = {grant_b, grant_a};
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               run_d   = 1'b0;
               fun_d   = '0;
               owner_d = 2'b00;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         done_q  <= 1'b0;
         fun_q   <= '0;
         owner_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         ack_a_q <= ack_a_d;
         ack_b_q <= ack_b_d;
         done_q  <= done_d;
         fun_q   <= fun_d;
         owner_q <= owner_d;
      end
   end

   assign bus.ack_a   = ack_a_q;
   assign bus.ack_b   = ack_b_q;
   assign bus.run     = run_q;
   assign bus.done    = done_q;
   assign bus.fun_out = fun_q;
   assign bus.owner   = owner_q;
endmodule
